pc_sequencer: RTL
=================

# pc_sequencer

Next-PC sequencer for the MUSA instruction-fetch stage, and the initiator side of the return-address stack protocol. It owns the 13-bit program counter and selects the next PC among sequential, jump, taken-branch, call and return. It drives the stack's push/pop strobes and consumes the popped return address. It keeps its own depth count so it raises a sticky fault instead of issuing an illegal push or pop.

## Interface
- `PC_W`, 13, PC and address width
- `DEPTH`, 8, stack capacity in entries; must match the attached stack
- `RESET_PC`, 13'h0000, PC value loaded on reset

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clock `clk`
- `instr_valid`  in  1  decoded control-flow fields below are valid this cycle
- `is_call`  in  1  current instruction is CALL
- `is_ret`  in  1  current instruction is RET
- `is_jump`  in  1  current instruction is unconditional jump
- `branch_taken`  in  1  current instruction is a taken conditional branch
- `target`  in  PC_W  jump/branch/call destination
- `stall`  in  1  pipeline hold; freezes PC, state and strobes
- `stack_out`  in  PC_W  popped address from stack, valid the cycle after a pop strobe
- `stack_overflow`  in  1  stack error flag
- `pc`  out  PC_W  current fetch address (registered)
- `fetch_en`  out  1  fetch at `pc` this cycle
- `write_stack`  out  1  push strobe, one cycle
- `read_stack`  out  1  pop strobe, one cycle
- `push_data`  out  PC_W  return address to push, `pc + 1`
- `busy`  out  1  RET in progress, waiting for `stack_out`
- `fault`  out  1  sticky stack-misuse fault

## Operation
- States: `IDLE`, `POP_WAIT`, `FAULT`.
- Internal `depth` counter, 0..DEPTH, is `$clog2(DEPTH)+1` bits wide.
- Accept condition: the cycle is accepted when `state==IDLE && instr_valid && !stall`.
- Decode priority on accept: ret > call > jump > branch_taken > sequential. Lower-priority fields are ignored when a higher one is set.
- **Sequential:** `pc <= pc + 1`, with modulo-2^PC_W wrap (1FFF -> 0000).
- **Jump / taken branch:** `pc <= target`.
- **CALL, `depth < DEPTH`:**
  - `write_stack=1` combinationally in the accept cycle.
  - `push_data = pc + 1` (wraps).
  - `depth++` and `pc <= target` at the edge.
- **CALL, `depth == DEPTH`:** no strobe; go to `FAULT`; pc holds.
- **RET, `depth > 0`:**
  - `read_stack=1` combinationally in the accept cycle.
  - `depth--` at the edge; go to `POP_WAIT`.
- **RET, `depth == 0`:** no strobe; go to `FAULT`.
- **POP_WAIT:**
  - `busy=1`, `fetch_en=0`, no strobes.
  - If `!stall`: `pc <= stack_out` and go to `IDLE`.
  - If `stall`: hold; the stack keeps `stack_out` stable.
- **FAULT:**
  - `fault=1`, `fetch_en=0`, no strobes; pc and depth frozen.
  - Exit only by reset.
- `stack_overflow==1` in any state forces `FAULT` at the next edge. It overrides any transition in that cycle, but a strobe already driven combinationally in that cycle is not retracted.
- `fetch_en = (state==IDLE) && !stall`.
- `push_data` is driven continuously as `pc + 1`; it is meaningful only when `write_stack=1`.

## Timing
- Reset (sampled at edge): `pc=RESET_PC`, `depth=0`, state `IDLE`, `fault=0`, `busy=0`.
  - First cycle after reset: `fetch_en=1` if not stalled.
  - `write_stack=0` and `read_stack=0` while `reset` is high.
- Reset mid-RET (in POP_WAIT): returns to IDLE with `depth=0`. The stack shares `reset`, so both sides stay consistent.
- Strobes are single-cycle and combinational from registered state plus inputs. The stack samples them at the same edge that updates `pc`.
- Latencies:
  - Sequential, jump, branch and CALL: new pc visible 1 cycle after accept.
  - RET: 2 cycles (accept -> POP_WAIT -> new pc), plus any stall cycles spent in POP_WAIT.
- `stall` in the accept cycle: no accept, no strobe, no pc or depth change.
- Back-to-back CALL/RET: legal on every IDLE cycle. A CALL immediately after a RET is accepted only after POP_WAIT completes.
- `instr_valid=0` in IDLE: pc holds, `fetch_en` stays 1.

## Test plan
- **Reset and sequential:** apply reset, then 4 cycles with `instr_valid`, no flags -> pc 0000, 0001, 0002, 0003, 0004; strobes 0; `fetch_en=1`.
- **Call/return round trip:**
  - At pc=0010, CALL target 0100 -> `write_stack=1` with `push_data=0011` for one cycle; pc=0100 next cycle.
  - Later, RET -> `read_stack=1` for one cycle; `busy=1` for one cycle; pc=0011 on the following cycle.
- **Nested full stack:**
  - 8 CALLs -> 8 push strobes; depth=8.
  - 9th CALL -> no strobe, `fault=1` next cycle, pc frozen, `fetch_en=0`.
  - Reset clears `fault` and sets pc=0000.
- **Underflow:** RET with depth 0 after reset -> no `read_stack`, `fault=1` next cycle; further inputs ignored until reset.
- **Stall in POP_WAIT and PC wrap:**
  - Hold `stall` 3 cycles after a RET accept -> pc unchanged, `busy=1` throughout; pc loads `stack_out` on the first unstalled edge.
  - Sequential step at pc=1FFF -> 0000.
  - CALL at pc=1FFF -> `push_data=0000`.
- **Priority and external fault:**
  - `is_call`, `is_jump` and `branch_taken` all set -> only the CALL action occurs.
  - Assert `stack_overflow` for 1 cycle in IDLE -> `FAULT` next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer and return-address stack initiator
//
// Purpose:
//   Owns the fetch program counter and chooses the next PC from sequential,
//   jump, taken branch, CALL and RET. Drives the push/pop strobes of an
//   attached return-address stack and loads the popped return address one
//   cycle after the pop. A private depth count keeps the strobes legal. An
//   illegal push or pop, or a stack error flag, sends the block into a sticky
//   fault state that only reset clears.
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high reset
//   i_instr_valid     in   control-flow fields valid this cycle
//   i_is_call         in   CALL
//   i_is_ret          in   RET
//   i_is_jump         in   unconditional jump
//   i_branch_taken    in   taken conditional branch
//   i_target          in   jump/branch/call destination
//   i_stall           in   pipeline hold
//   i_stack_out       in   popped return address (valid cycle after pop)
//   i_stack_overflow  in   stack error flag
//   o_pc              out  current fetch address (registered)
//   o_fetch_en        out  fetch at o_pc this cycle
//   o_write_stack     out  push strobe
//   o_read_stack      out  pop strobe
//   o_push_data       out  return address to push (o_pc + 1)
//   o_busy            out  RET waiting for the popped address
//   o_fault           out  sticky stack-misuse fault

module pc_sequencer #(
    parameter int                PC_W     = 13,
    parameter int                DEPTH    = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_instr_valid,
    input  logic            i_is_call,
    input  logic            i_is_ret,
    input  logic            i_is_jump,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_target,
    input  logic            i_stall,
    input  logic [PC_W-1:0] i_stack_out,
    input  logic            i_stack_overflow,
    output logic [PC_W-1:0] o_pc,
    output logic            o_fetch_en,
    output logic            o_write_stack,
    output logic            o_read_stack,
    output logic [PC_W-1:0] o_push_data,
    output logic            o_busy,
    output logic            o_fault
);

    localparam int                 DEPTH_W   = $clog2(DEPTH) + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_POP_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_busy;
    logic               r_fault;

    logic               w_accept;
    logic               w_do_ret;
    logic               w_do_call;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [PC_W-1:0]    w_pc_inc;

    // Decode priority: ret > call > jump > branch > sequential.
    assign w_accept  = (r_state == ST_IDLE) && i_instr_valid && !i_stall;
    assign w_do_ret  = w_accept && i_is_ret;
    assign w_do_call = w_accept && !i_is_ret && i_is_call;
    assign w_push_ok = (r_depth != DEPTH_MAX);
    assign w_pop_ok  = (r_depth != '0);
    assign w_pc_inc  = r_pc + PC_W'(1);

    // Strobes are combinational so the stack samples them at the same edge
    // that moves the PC. They are held low while reset is asserted.
    assign o_write_stack = !reset && w_do_call && w_push_ok;
    assign o_read_stack  = !reset && w_do_ret && w_pop_ok;
    assign o_fetch_en    = (r_state == ST_IDLE) && !i_stall;
    assign o_push_data   = w_pc_inc;
    assign o_pc          = r_pc;
    assign o_busy        = r_busy;
    assign o_fault       = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_depth <= '0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else if (i_stack_overflow) begin
            // External error wins over any transition. A strobe already
            // driven this cycle still reaches the stack, so track it to keep
            // the depth count aligned with the stack's own.
            r_state <= ST_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
            if (o_write_stack) begin
                r_depth <= r_depth + DEPTH_W'(1);
            end else if (o_read_stack) begin
                r_depth <= r_depth - DEPTH_W'(1);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (i_is_ret) begin
                            if (w_pop_ok) begin
                                r_depth <= r_depth - DEPTH_W'(1);
                                r_state <= ST_POP_WAIT;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_FAULT;
                                r_fault <= 1'b1;
                            end
                        end else if (i_is_call) begin
                            if (w_push_ok) begin
                                r_depth <= r_depth + DEPTH_W'(1);
                                r_pc    <= i_target;
                            end else begin
                                r_state <= ST_FAULT;
                                r_fault <= 1'b1;
                            end
                        end else if (i_is_jump || i_branch_taken) begin
                            r_pc <= i_target;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end

                ST_POP_WAIT: begin
                    // The stack holds i_stack_out stable across stalls.
                    if (!i_stall) begin
                        r_pc    <= i_stack_out;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_FAULT: begin
                    r_fault <= 1'b1;
                end

                default: begin
                    r_state <= ST_FAULT;
                    r_busy  <= 1'b0;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

endmodule
